// File: rtl/act_skew_feeder.sv
// Activation skew feeder: latches an NxN matrix, replays it as diagonally skewed row streams,
// zero-fills a drain window, then pulses done. Optional macro SKEW_STALL_EN adds a stall input.
module act_skew_feeder #(
   parameter int unsigned N            = 3,
   parameter int unsigned DW           = 8,
   parameter int unsigned DRAIN_CYCLES = 3
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N*N*DW-1:0] act_in,
`ifdef SKEW_STALL_EN
   input  logic              stall,
`endif
   output logic [N*DW-1:0]   row_act,
   output logic [N-1:0]      row_vld,
   output logic              frame_start,
   output logic              busy,
   output logic              done
);

   localparam int unsigned FeedLen = 2 * N - 1;
   localparam int unsigned CntMax  = (FeedLen > DRAIN_CYCLES) ? FeedLen : DRAIN_CYCLES;
   localparam int unsigned CW      = (CntMax > 1) ? $clog2(CntMax) : 1;
   localparam logic [CW-1:0] FeedLast  = CW'(FeedLen - 1);
   localparam logic [CW-1:0] DrainLast = CW'((DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StFeed, StDrain, StDone} state_e;

   state_e              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [N*N*DW-1:0]   mat_q, mat_d;
   logic                hold;
   logic                held;

`ifdef SKEW_STALL_EN
   logic held_q;

   assign hold = stall && ((state_q == StFeed) || (state_q == StDrain));
   assign held = held_q;

   // Remembers a held cycle so frame_start stays a single-cycle pulse across a stall.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         held_q <= 1'b0;
      end else begin
         held_q <= hold;
      end
   end
`else
   assign hold = 1'b0;
   assign held = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mat_d   = mat_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               mat_d   = act_in;
               cnt_d   = '0;
               state_d = StFeed;
            end
         end
         StFeed: begin
            if (!hold) begin
               if (cnt_q == FeedLast) begin
                  cnt_d   = '0;
                  state_d = (DRAIN_CYCLES == 0) ? StDone : StDrain;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         StDrain: begin
            if (!hold) begin
               if (cnt_q == DrainLast) begin
                  cnt_d   = '0;
                  state_d = StDone;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         mat_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mat_q   <= mat_d;
      end
   end

   // Lane r carries column r, delayed by r cycles: element A[cnt-r][r].
   always_comb begin
      int k;
      k       = 0;
      row_act = '0;
      row_vld = '0;
      for (int r = 0; r < int'(N); r++) begin
         k = int'(cnt_q) - r;
         if ((state_q == StFeed) && (k >= 0) && (k < int'(N))) begin
            row_act[r*int'(DW) +: DW] = mat_q[(k * int'(N) + r) * int'(DW) +: DW];
            row_vld[r]                = 1'b1;
         end
      end
   end

   assign in_ready    = (state_q == StIdle) && nrst;
   assign busy        = (state_q != StIdle);
   assign done        = (state_q == StDone);
   assign frame_start = (state_q == StFeed) && (cnt_q == '0) && !held;

endmodule

// File: tb/tb_act_skew_feeder.sv
// Directed bench for act_skew_feeder (N=3, DW=8): default DUT plus a DRAIN_CYCLES=0 instance.
module tb_act_skew_feeder;

   logic        clk = 1'b0;
   logic        nrst;
   logic        in_valid;
   logic [71:0] act_in;
`ifdef SKEW_STALL_EN
   logic        stall;
`endif
   logic        in_ready, frame_start, busy, done;
   logic [23:0] row_act;
   logic [2:0]  row_vld;
   logic        z_in_ready, z_frame_start, z_busy, z_done;
   logic [23:0] z_row_act;
   logic [2:0]  z_row_vld;

   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   act_skew_feeder #(.N(3), .DW(8), .DRAIN_CYCLES(3)) dut (
      .clk        (clk),
      .nrst       (nrst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .act_in     (act_in),
`ifdef SKEW_STALL_EN
      .stall      (stall),
`endif
      .row_act    (row_act),
      .row_vld    (row_vld),
      .frame_start(frame_start),
      .busy       (busy),
      .done       (done)
   );

   act_skew_feeder #(.N(3), .DW(8), .DRAIN_CYCLES(0)) dut_z (
      .clk        (clk),
      .nrst       (nrst),
      .in_valid   (in_valid),
      .in_ready   (z_in_ready),
      .act_in     (act_in),
`ifdef SKEW_STALL_EN
      .stall      (stall),
`endif
      .row_act    (z_row_act),
      .row_vld    (z_row_vld),
      .frame_start(z_frame_start),
      .busy       (z_busy),
      .done       (z_done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // A[r][c] = base + 3r + c
   function automatic logic [71:0] mk(input int base);
      logic [71:0] v;
      v = '0;
      for (int i = 0; i < 9; i++) v[i*8 +: 8] = 8'(base + i);
      return v;
   endfunction

   task automatic check_lanes(input string tag, input logic [23:0] act, input logic [2:0] vld);
      check({tag, "_act"}, {8'h0, row_act}, {8'h0, act});
      check({tag, "_vld"}, {29'h0, row_vld}, {29'h0, vld});
   endtask

   initial begin
      nrst     = 1'b0;
      in_valid = 1'b1;
      act_in   = mk(1);
`ifdef SKEW_STALL_EN
      stall    = 1'b0;
`endif
      // Reset held for two cycles with in_valid high
      for (int i = 0; i < 2; i++) begin
         step();
         check("rst_ready", {31'h0, in_ready}, 32'h0);
         check_lanes("rst", 24'h0, 3'b000);
         check("rst_done", {31'h0, done}, 32'h0);
      end
      nrst     = 1'b1;
      in_valid = 1'b0;
      #1;
      check("rel_ready", {31'h0, in_ready}, 32'h1);
      check("rel_busy", {31'h0, busy}, 32'h0);

      // Frame 1: A = [[1,2,3],[4,5,6],[7,8,9]]
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      act_in   = 72'hFF_FFFF_FFFF_FFFF_FFFF;
      check_lanes("f1_c0", 24'h000001, 3'b001);
      check("f1_fs0", {31'h0, frame_start}, 32'h1);
      check("f1_busy", {31'h0, busy}, 32'h1);
      check("f1_ready", {31'h0, in_ready}, 32'h0);
      step();
      check_lanes("f1_c1", 24'h000204, 3'b011);
      check("f1_fs1", {31'h0, frame_start}, 32'h0);
      step();
      check_lanes("f1_c2", 24'h030507, 3'b111);
      step();
      check_lanes("f1_c3", 24'h060800, 3'b110);
      step();
      check_lanes("f1_c4", 24'h090000, 3'b100);
      check("f1_done4", {31'h0, done}, 32'h0);
      check("z_done4", {31'h0, z_done}, 32'h0);
      step();
      check_lanes("f1_d0", 24'h0, 3'b000);
      check("f1_done5", {31'h0, done}, 32'h0);
      check("z_done5", {31'h0, z_done}, 32'h1);
      check("z_act5", {8'h0, z_row_act}, 32'h0);
      step();
      check("z_done6", {31'h0, z_done}, 32'h0);
      check("z_ready6", {31'h0, z_in_ready}, 32'h1);
      step();
      check("f1_done7", {31'h0, done}, 32'h0);
      step();
      check("f1_done8", {31'h0, done}, 32'h1);
      check_lanes("f1_done_lanes", 24'h0, 3'b000);
      check("f1_ready8", {31'h0, in_ready}, 32'h0);
      step();
      check("f1_done9", {31'h0, done}, 32'h0);
      check("f1_ready9", {31'h0, in_ready}, 32'h1);
      check("f1_busy9", {31'h0, busy}, 32'h0);

      // Frames 2 and 3 with in_valid held high
      in_valid = 1'b1;
      act_in   = mk(16);
      step();
      act_in   = mk(64);
      check_lanes("f2_c0", 24'h000010, 3'b001);
      step();
      step();
      check_lanes("f2_c2", 24'h121416, 3'b111);
      for (int i = 3; i < 8; i++) begin
         step();
         check("f2_ready", {31'h0, in_ready}, 32'h0);
      end
      step();
      check("f2_done", {31'h0, done}, 32'h1);
      step();
      check("f2_ready9", {31'h0, in_ready}, 32'h1);
      step();
      check_lanes("f3_c0", 24'h000040, 3'b001);
      check("f3_fs", {31'h0, frame_start}, 32'h1);
      in_valid = 1'b0;
      step();
      step();
      check_lanes("f3_c2", 24'h424446, 3'b111);

      // Reset mid-frame at cnt=2
      nrst = 1'b0;
      step();
      check_lanes("mrst", 24'h0, 3'b000);
      check("mrst_done", {31'h0, done}, 32'h0);
      check("mrst_busy", {31'h0, busy}, 32'h0);
      check("mrst_fs", {31'h0, frame_start}, 32'h0);
      nrst = 1'b1;
      #1;
      check("mrst_ready", {31'h0, in_ready}, 32'h1);
      step();
      check("mrst_done2", {31'h0, done}, 32'h0);
      check("mrst_ready2", {31'h0, in_ready}, 32'h1);

      // Fresh frame after the abort
      in_valid = 1'b1;
      act_in   = mk(1);
      step();
      in_valid = 1'b0;
      check_lanes("f4_c0", 24'h000001, 3'b001);
      step();
      check_lanes("f4_c1", 24'h000204, 3'b011);
`ifdef SKEW_STALL_EN
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_lanes("stall_hold", 24'h000204, 3'b011);
         check("stall_fs", {31'h0, frame_start}, 32'h0);
      end
      stall = 1'b0;
`endif
      step();
      check_lanes("f4_c2", 24'h030507, 3'b111);
      step();
      check_lanes("f4_c3", 24'h060800, 3'b110);
      step();
      check_lanes("f4_c4", 24'h090000, 3'b100);
      for (int i = 5; i < 8; i++) begin
         step();
         check("f4_drain_done", {31'h0, done}, 32'h0);
      end
      step();
      check("f4_done", {31'h0, done}, 32'h1);
      step();
      check("f4_ready", {31'h0, in_ready}, 32'h1);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/act_skew_feeder.md
Name: act_skew_feeder

Overview:
Upstream stage of the 3x3 systolic PE array. Accepts a full NxN activation matrix in one valid/ready transfer and latches it. Replays it as N diagonally skewed per-row streams so row r of the array sees its operands r cycles after row 0. Then holds zeros for a drain window and signals completion so the array top can capture its results.

Parameters:
N, 3, array dimension (rows/cols of activation matrix and PE array); legal 2..8
DW, 8, activation element width in bits
DRAIN_CYCLES, 3, zero-fill cycles after feeding so partial sums flush through the array; 0 legal

Ports:
clk  input  1  clock
nrst  input  1  reset, synchronous, active-low
in_valid  input  1  upstream offers a matrix
in_ready  output  1  block can accept a matrix
act_in  input  N*N*DW  flattened matrix; A[r][c] = act_in[(r*N+c)*DW +: DW]
row_act  output  N*DW  skewed activation to array row r = row_act[r*DW +: DW]
row_vld  output  N  row_act lane r carries a real element
frame_start  output  1  one-cycle pulse on first feed cycle (array clears accumulators)
busy  output  1  high in FEED, DRAIN, DONE
done  output  1  one-cycle pulse after drain completes

Behaviour:
- Reset, sampled on posedge clk with nrst=0: state=IDLE, cnt=0, matrix register=0. All outputs 0, including in_ready, which is held low while nrst=0. Reset mid-frame aborts the frame immediately, with no done pulse.
- States: IDLE, FEED, DRAIN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge where in_valid&&in_ready, latch act_in, set cnt=0, go to FEED.
  - act_in is ignored at all other times.
- FEED:
  - Lasts 2N-1 cycles, cnt=0..2N-2.
  - Lane r outputs A[cnt-r][r] with row_vld[r]=1 when 0<=cnt-r<=N-1; otherwise the lane outputs 0 with row_vld[r]=0.
  - frame_start=1 only when cnt=0.
  - After cnt=2N-2: go to DRAIN with cnt=0, or to DONE if DRAIN_CYCLES=0.
- DRAIN:
  - DRAIN_CYCLES cycles, cnt=0..DRAIN_CYCLES-1.
  - row_act=0, row_vld=0.
  - Then go to DONE.
- DONE:
  - Exactly one cycle with done=1; row_act=0.
  - Next state is IDLE.
- in_ready is 0 in every state except IDLE, so there is no overlap between frames.
- Outputs are driven only from registered state (cnt, state, matrix register). There is no combinational path from in_valid or act_in to any output except through registers.
- Latency: the first FEED cycle is the cycle immediately after the accepting edge.
  - Accept-to-done = 2N-1+DRAIN_CYCLES+1 cycles.
  - in_ready returns the following cycle.
  - For N=3, D=3, with accept at edge 0: FEED cycles 1–5, DRAIN 6–8, done in cycle 9, in_ready=1 in cycle 10.
- cnt width: clog2(max(2N-1, DRAIN_CYCLES, 1)). cnt never wraps; the state transition occurs at the terminal count.
- If in_valid is held high continuously, one matrix is taken per frame, at each IDLE cycle.

Optional Feature:
Macro SKEW_STALL_EN.
- Defined:
  - Adds input port stall (1 bit).
  - While stall=1 in FEED or DRAIN: state, cnt and all outputs hold their current values. row_vld and row_act stay as they are, so the array must also be stalled.
  - frame_start and done pulses are not re-issued while held; they deassert after their single cycle.
  - stall is ignored in IDLE and DONE.
- Undefined: no stall port; behaviour as above.

Test Plan:
- Reset: nrst=0 for 2 cycles with in_valid=1 -> in_ready=0, row_act=0, row_vld=0, done=0; in_ready=1 in the first cycle after nrst=1.
- Single frame, A=[[1,2,3],[4,5,6],[7,8,9]], N=3, D=3:
  - Lane0 = 1,4,7 at cnt 0..2; lane1 = 2,5,8 at cnt 1..3; lane2 = 3,6,9 at cnt 2..4.
  - At cnt=2: row_act = {3,5,7}, row_vld=3'b111.
  - At cnt=0: row_vld=3'b001; at cnt=4: row_vld=3'b100.
  - frame_start in cycle 1; done in cycle 9 only.
- Back-to-back: in_valid held high with two matrices -> second accepted at edge ending cycle 10; act_in changes during busy have no effect on row_act.
- DRAIN_CYCLES=0 build: done immediately follows the last FEED cycle; accept-to-done = 6 cycles.
- Reset mid-frame: nrst=0 at cnt=2 of FEED -> next cycle all outputs 0, no done pulse, in_ready=1 after release; a fresh frame then replays correctly.
- SKEW_STALL_EN build: stall=1 for 3 cycles at cnt=1 -> row_act={0,2,4}, row_vld=3'b011 held for 3 extra cycles; done delayed by exactly 3 cycles (cycle 12).
